// File: rtl/vga_pkg.sv
// vga_pkg: definitions shared by the VGA scan-out blocks.
//   MODE_*    run-time scan-out mode encoding (the 'mode' input of vga_scanout)
//   SRC_*     per-pixel colour source carried down the alignment pipeline
//   vga_total sum of the four timing segments of one axis (H or V)
package vga_pkg;

    localparam logic [1:0] MODE_FB    = 2'd0;  // native framebuffer
    localparam logic [1:0] MODE_FB2X  = 2'd1;  // 2x pixel-doubled framebuffer
    localparam logic [1:0] MODE_BARS  = 2'd2;  // colour-bar test pattern
    localparam logic [1:0] MODE_BLACK = 2'd3;  // forced black

    localparam logic [1:0] SRC_BLACK = 2'd0;
    localparam logic [1:0] SRC_FB    = 2'd1;
    localparam logic [1:0] SRC_BAR   = 2'd2;

    // Total length of one axis: active + front porch + sync + back porch.
    function automatic int vga_total(input int active, input int fp,
                                     input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: pixel-clock enable, horizontal/vertical counters and the
// undelayed raster flags. Reusable by any block that needs VGA timing.
//   clk, rst     system clock, asynchronous active-low reset
//   pix_ce       one-clk enable every CLK_DIV clocks; all raster state moves on it
//   h, v         current pixel column / line
//   active       (h, v) is inside the visible area
//   hs_on, vs_on sync pulse asserted (logical, polarity applied elsewhere)
//   line_end     h is the last column of the line
//   frame_end    h and v are the last column and line of the frame
//   frame_start  pix_ce on the tick where h = 0, v = 0
//   vblank       v is in the vertical blanking interval
module vga_timing
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HW       = 10,
    parameter int VW       = 10
) (
    input  logic          clk,
    input  logic          rst,
    output logic          pix_ce,
    output logic [HW-1:0] h,
    output logic [VW-1:0] v,
    output logic          active,
    output logic          hs_on,
    output logic          vs_on,
    output logic          line_end,
    output logic          frame_end,
    output logic          frame_start,
    output logic          vblank
);

    localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int DW      = $clog2(CLK_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0] div;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div <= '0;
            h   <= '0;
            v   <= '0;
        end else begin
            if (pix_ce) begin
                div <= '0;
            end else begin
                div <= div + DW'(1);
            end
            if (pix_ce) begin
                if (line_end) begin
                    h <= '0;
                    // Line and frame wrap on the same tick at the last pixel.
                    v <= (v == V_LAST) ? '0 : v + VW'(1);
                end else begin
                    h <= h + HW'(1);
                end
            end
        end
    end

    assign pix_ce      = (div == DIV_LAST);
    assign line_end    = (h == H_LAST);
    assign frame_end   = line_end && (v == V_LAST);
    assign active      = (h < H_ACT) && (v < V_ACT);
    assign hs_on       = (h >= HS_BEG) && (h < HS_END);
    assign vs_on       = (v >= VS_BEG) && (v < VS_END);
    assign frame_start = pix_ce && (h == '0) && (v == '0);
    assign vblank      = (v >= V_ACT);

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: parametrised VGA scan-out engine. Generates framebuffer read
// addresses, aligns returned pixel data with delayed sync/blank and drives
// registered RGB and sync pins.
//   clk, rst          system clock, asynchronous active-low reset
//   mode              0 native fb, 1 2x doubled fb, 2 colour bars, 3 black
//   pix_data          framebuffer read data {R,G,B}, RD_LAT pixel ticks after rd_en
//   rd_en, addr       read strobe and address
//   red/green/blue    registered colour outputs
//   hsync, vsync      registered syncs at HS_POL / VS_POL while asserted
//   frame_start       one-clk pulse on the tick of pixel (0,0), undelayed
//   vblank            high while v >= V_ACTIVE, undelayed
//
// Read port protocol: rd_en is a one-clk strobe that is only ever high on a
// pixel tick; addr is valid in that same clk. There is no back-pressure: the
// RAM must return the word on pix_data by the tick RD_LAT ticks later, where
// it is sampled on that tick's pix_ce.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int   CLK_DIV  = 4,
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CBITS    = 4,
    parameter int   ADDR_W   = 19,
    parameter int   RD_LAT   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mode,
    input  logic [3*CBITS-1:0] pix_data,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  addr,
    output logic [CBITS-1:0]   red,
    output logic [CBITS-1:0]   green,
    output logic [CBITS-1:0]   blue,
    output logic               hsync,
    output logic               vsync,
    output logic               frame_start,
    output logic               vblank
);

    localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int BCW     = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int PW      = 3 * CBITS;

    localparam logic [HW-1:0]  H_ACT_LAST = HW'(H_ACTIVE - 1);
    // Doubled mode only fetches complete line pairs; an unpaired last line
    // with odd V_ACTIVE is shown black instead of reading past the image.
    localparam logic [VW-1:0]  V_PAIRS    = VW'((V_ACTIVE / 2) * 2);
    localparam logic [BCW-1:0] BAR_LAST   = BCW'(BAR_W - 1);

    logic          pix_ce;
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          active;
    logic          hs_on;
    logic          vs_on;
    logic          line_end;
    logic          frame_end;

    vga_timing #(
        .CLK_DIV  (CLK_DIV),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HW       (HW),
        .VW       (VW)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .pix_ce      (pix_ce),
        .h           (h),
        .v           (v),
        .active      (active),
        .hs_on       (hs_on),
        .vs_on       (vs_on),
        .line_end    (line_end),
        .frame_end   (frame_end),
        .frame_start (frame_start),
        .vblank      (vblank)
    );

    // ------------------------------------------------------------------
    // Mode latch. The mode register loads on frame_start, so the mode in
    // force for the first pixel of a frame is the live input; cur_mode
    // forwards it so the whole new frame, pixel (0,0) included, uses it.
    // ------------------------------------------------------------------
    logic [1:0] mode_q;
    logic [1:0] cur_mode;

    assign cur_mode = frame_start ? mode : mode_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q <= MODE_FB;
        end else if (frame_start) begin
            mode_q <= mode;
        end
    end

    // ------------------------------------------------------------------
    // Fetch decision and colour source for the current pixel.
    // ------------------------------------------------------------------
    logic       fetch;
    logic [1:0] src;

    always_comb begin
        fetch = 1'b0;
        if (active) begin
            if (cur_mode == MODE_FB) begin
                fetch = 1'b1;
            end else if (cur_mode == MODE_FB2X) begin
                fetch = (v < V_PAIRS);
            end
        end
    end

    always_comb begin
        src = SRC_BLACK;
        if (fetch) begin
            src = SRC_FB;
        end else if (active && (cur_mode == MODE_BARS)) begin
            src = SRC_BAR;
        end
    end

    assign rd_en = pix_ce && fetch;

    // ------------------------------------------------------------------
    // Incremental address generation (no multiplier).
    // Native: +1 per fetched pixel. Doubled: +1 after each odd column; at
    // the end of an even line rewind to the line start so the line is read
    // twice, at the end of an odd line advance the line start instead.
    // The counters clear on the last tick of every frame so the next frame
    // starts at address 0 whatever mode it runs in.
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] line_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
            line_q <= '0;
        end else if (pix_ce) begin
            if (frame_end) begin
                addr_q <= '0;
                line_q <= '0;
            end else if (fetch) begin
                if (cur_mode == MODE_FB) begin
                    addr_q <= addr_q + ADDR_W'(1);
                end else if (h == H_ACT_LAST) begin
                    if (!v[0]) begin
                        addr_q <= line_q;
                    end else begin
                        addr_q <= addr_q + ADDR_W'(1);
                        line_q <= addr_q + ADDR_W'(1);
                    end
                end else if (h[0]) begin
                    addr_q <= addr_q + ADDR_W'(1);
                end
            end
        end
    end

    assign addr = addr_q;

    // ------------------------------------------------------------------
    // Colour-bar index: steps every H_ACTIVE/8 pixels, restarts each line.
    // ------------------------------------------------------------------
    logic [BCW-1:0] bar_sub;
    logic [2:0]     bar;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bar_sub <= '0;
            bar     <= '0;
        end else if (pix_ce) begin
            if (line_end) begin
                bar_sub <= '0;
                bar     <= '0;
            end else if (bar_sub == BAR_LAST) begin
                bar_sub <= '0;
                bar     <= bar + 3'd1;
            end else begin
                bar_sub <= bar_sub + BCW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Alignment pipeline: RD_LAT stages so that stage RD_LAT-1 describes
    // the same pixel whose data is on pix_data; the output register adds
    // the final tick. A cleared pipeline reads as inactive, syncs idle.
    // ------------------------------------------------------------------
    logic       p_act [RD_LAT];
    logic       p_hs  [RD_LAT];
    logic       p_vs  [RD_LAT];
    logic [1:0] p_src [RD_LAT];
    logic [2:0] p_bar [RD_LAT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                p_act[i] <= 1'b0;
                p_hs[i]  <= 1'b0;
                p_vs[i]  <= 1'b0;
                p_src[i] <= SRC_BLACK;
                p_bar[i] <= 3'd0;
            end
        end else if (pix_ce) begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                p_act[i] <= p_act[i-1];
                p_hs[i]  <= p_hs[i-1];
                p_vs[i]  <= p_vs[i-1];
                p_src[i] <= p_src[i-1];
                p_bar[i] <= p_bar[i-1];
            end
            p_act[0] <= active;
            p_hs[0]  <= hs_on;
            p_vs[0]  <= vs_on;
            p_src[0] <= src;
            p_bar[0] <= bar;
        end
    end

    // ------------------------------------------------------------------
    // Output registers.
    // ------------------------------------------------------------------
    logic [2:0]    d_bar;
    logic [PW-1:0] bar_rgb;
    logic [PW-1:0] rgb_q;

    assign d_bar   = p_bar[RD_LAT-1];
    assign bar_rgb = {{CBITS{d_bar[2]}}, {CBITS{d_bar[1]}}, {CBITS{d_bar[0]}}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb_q <= '0;
            hsync <= ~HS_POL;
            vsync <= ~VS_POL;
        end else if (pix_ce) begin
            hsync <= p_hs[RD_LAT-1] ? HS_POL : ~HS_POL;
            vsync <= p_vs[RD_LAT-1] ? VS_POL : ~VS_POL;
            if (!p_act[RD_LAT-1]) begin
                rgb_q <= '0;
            end else begin
                case (p_src[RD_LAT-1])
                    SRC_FB:  rgb_q <= pix_data;
                    SRC_BAR: rgb_q <= bar_rgb;
                    default: rgb_q <= '0;
                endcase
            end
        end
    end

    assign red   = rgb_q[3*CBITS-1:2*CBITS];
    assign green = rgb_q[2*CBITS-1:CBITS];
    assign blue  = rgb_q[CBITS-1:0];

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: self-checking bench for vga_scanout on a small raster
// (16x5 visible, 24x9 total, CLK_DIV 3, RD_LAT 2, HS_POL 1) so that many
// frames, every mode and a mid-frame reset fit in a short run.
// The reference derives every pixel from its raster position (position =
// clocks since reset / CLK_DIV) with plain arithmetic; a framebuffer model
// answers reads with RD_LAT ticks of latency from a random memory image.
module tb_vga_scanout;

    localparam int   CLK_DIV = 3;
    localparam int   HA  = 16;
    localparam int   HFP = 2;
    localparam int   HSW = 3;
    localparam int   HBP = 3;
    localparam int   VA  = 5;
    localparam int   VFP = 1;
    localparam int   VSW = 2;
    localparam int   VBP = 1;
    localparam logic HS_POL = 1'b1;
    localparam logic VS_POL = 1'b0;
    localparam int   CB  = 4;
    localparam int   AW  = 19;
    localparam int   L   = 2;
    localparam int   HT  = HA + HFP + HSW + HBP;   // 24
    localparam int   VT  = VA + VFP + VSW + VBP;   // 9
    localparam int   FRAME = HT * VT;              // 216 pixels
    localparam int   W   = 3 * CB + 2;
    localparam int   RUN = 12000;
    localparam int   RST_AT = 7000;
    localparam logic [W-1:0] RESET_WORD = {12'h000, ~HS_POL, ~VS_POL};

    logic          clk;
    logic          rst;
    logic [1:0]    mode;
    logic [11:0]   pix_data;
    logic          rd_en;
    logic [AW-1:0] addr;
    logic [CB-1:0] red;
    logic [CB-1:0] green;
    logic [CB-1:0] blue;
    logic          hsync;
    logic          vsync;
    logic          frame_start;
    logic          vblank;

    vga_scanout #(
        .CLK_DIV (CLK_DIV), .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
        .HS_POL (HS_POL), .VS_POL (VS_POL), .CBITS (CB), .ADDR_W (AW), .RD_LAT (L)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .pix_data    (pix_data),
        .rd_en       (rd_en),
        .addr        (addr),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frame_start),
        .vblank      (vblank)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bench state ----------------
    logic [11:0]  mem [128];
    logic [W-1:0] exp_q [$];
    logic [11:0]  fbq [$];
    logic [W-1:0] dut_word;
    int n_chk;
    int n_fail;
    int k;
    int fr;
    logic [1:0] fmode;
    bit   frame_valid;
    int   cnt_rd;
    int   max_addr;
    logic hs_prev;
    logic vs_prev;
    bit   hs_seen;
    bit   vs_seen;
    int   hs_rise;
    int   vs_rise;

    assign dut_word = {red, green, blue, hsync, vsync};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (k=%0d, t=%0t)", name, act, exp, k, $time);
        end
    endtask

    // Expected registered output for raster pixel (h,v) in a frame of mode fm.
    function automatic logic [W-1:0] pixel_word(input int h, input int v, input logic [1:0] fm);
        logic [11:0] col;
        int am;
        int bar;
        logic hs_l;
        logic vs_l;
        col = 12'h000;
        if (h < HA && v < VA) begin
            if (fm == 2'd0) begin
                am  = v * HA + h;
                col = mem[am % 128];
            end else if (fm == 2'd1 && v < (VA / 2) * 2) begin
                am  = (v / 2) * (HA / 2) + h / 2;
                col = mem[am % 128];
            end else if (fm == 2'd2) begin
                bar = h / (HA / 8);
                col = {((bar & 4) != 0) ? 4'hF : 4'h0,
                       ((bar & 2) != 0) ? 4'hF : 4'h0,
                       ((bar & 1) != 0) ? 4'hF : 4'h0};
            end
        end
        hs_l = (h >= HA + HFP && h < HA + HFP + HSW) ? HS_POL : ~HS_POL;
        vs_l = (v >= VA + VFP && v < VA + VFP + VSW) ? VS_POL : ~VS_POL;
        return {col, hs_l, vs_l};
    endfunction

    task automatic check_reset();
        chk("rst_outputs", 32'(dut_word), 32'(RESET_WORD));
        chk("rst_rd_en", 32'(rd_en), 0);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_frame_start", 32'(frame_start), 0);
        chk("rst_vblank", 32'(vblank), 0);
    endtask

    task automatic release_reset();
        rst = 1'b1;
        k = 0;
        exp_q.delete();
        fbq.delete();
        frame_valid = 1'b0;
        hs_prev = ~HS_POL;
        vs_prev = ~VS_POL;
        hs_seen = 1'b0;
        vs_seen = 1'b0;
    endtask

    // Totals for a completed frame, hand-computed for the 16x5 raster.
    task automatic frame_checks();
        case (fmode)
            2'd0: begin
                chk("rd_count_native", cnt_rd, 80);
                chk("max_addr_native", max_addr, 79);
            end
            2'd1: begin
                chk("rd_count_doubled", cnt_rd, 64);
                chk("max_addr_doubled", max_addr, 15);
            end
            default: chk("rd_count_nofetch", cnt_rd, 0);
        endcase
    endtask

    task automatic step();
        int p;
        int h;
        int v;
        bit tick;
        bit fs;
        bit fetch;
        int am;
        logic [W-1:0] exp_w;
        k++;
        p    = k / CLK_DIV;
        tick = ((k % CLK_DIV) == CLK_DIV - 1);
        h    = p % HT;
        v    = (p / HT) % VT;
        // Mid-frame mode change; it must only apply from the next frame.
        if (tick && (p % FRAME) == 100) begin
            mode = (fr < 4) ? 2'(fr) : 2'($urandom_range(0, 3));
        end
        #1;
        fs = tick && h == 0 && v == 0;
        if (fs) begin
            if (frame_valid) frame_checks();
            fmode = mode;
            frame_valid = 1'b1;
            cnt_rd = 0;
            max_addr = 0;
            fr++;
        end
        fetch = (h < HA && v < VA) && (fmode == 2'd0 || (fmode == 2'd1 && v < (VA / 2) * 2));
        chk("rd_en", 32'(rd_en), 32'(tick && fetch));
        if (tick && fetch) begin
            am = (fmode == 2'd0) ? v * HA + h : (v / 2) * (HA / 2) + h / 2;
            chk("addr", 32'(addr), am);
        end
        chk("frame_start", 32'(frame_start), 32'(fs));
        chk("vblank", 32'(vblank), 32'(v >= VA));
        if (rd_en) begin
            cnt_rd++;
            if (int'(addr) > max_addr) max_addr = int'(addr);
        end

        // Registered outputs: pixel p-(L+1) is on the pins during position p.
        if (p >= L + 1) begin
            if (exp_q.size() == 0) begin
                chk("exp_queue_empty", 1, 0);
                exp_w = RESET_WORD;
            end else begin
                exp_w = exp_q[0];
            end
        end else begin
            exp_w = RESET_WORD;
        end
        chk("rgb_sync", 32'(dut_word), 32'(exp_w));
        if (tick) begin
            if (p >= L + 1 && exp_q.size() > 0) void'(exp_q.pop_front());
            exp_q.push_back(pixel_word(h, v, fmode));
        end

        // Framebuffer: data for a tick's request is presented L ticks later.
        if (tick) begin
            fbq.push_back(rd_en ? mem[addr[6:0]] : 12'($urandom));
            if (fbq.size() > L) pix_data = fbq.pop_front();
        end

        // Sync edge literals: first pulse (HA+HFP+L+1)*CLK_DIV = 63 clocks,
        // line 72 / pulse 9 clocks; first vsync 441, frame 648 / pulse 144.
        if (hsync !== hs_prev) begin
            if (hsync == HS_POL) begin
                if (!hs_seen) chk("first_hsync_clk", k, 63);
                else          chk("hsync_period", k - hs_rise, 72);
                hs_seen = 1'b1;
                hs_rise = k;
            end else if (hs_seen) begin
                chk("hsync_width", k - hs_rise, 9);
            end
            hs_prev = hsync;
        end
        if (vsync !== vs_prev) begin
            if (vsync == VS_POL) begin
                if (!vs_seen) chk("first_vsync_clk", k, 441);
                else          chk("vsync_period", k - vs_rise, 648);
                vs_seen = 1'b1;
                vs_rise = k;
            end else if (vs_seen) begin
                chk("vsync_width", k - vs_rise, 144);
            end
            vs_prev = vsync;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_chk = 0;
        n_fail = 0;
        k = 0;
        fr = 0;
        fmode = 2'd0;
        cnt_rd = 0;
        max_addr = 0;
        hs_rise = 0;
        vs_rise = 0;
        rst = 1'b0;
        mode = 2'd0;
        pix_data = 12'h000;
        for (int i = 0; i < 128; i++) mem[i] = 12'($urandom);
        repeat (3) @(negedge clk);
        #1;
        check_reset();
        @(negedge clk);
        release_reset();
        for (int cyc = 0; cyc < RUN; cyc++) begin
            @(negedge clk);
            if (cyc == RST_AT) begin
                rst = 1'b0;
                #1;
                check_reset();
                repeat (4) begin
                    @(negedge clk);
                    #1;
                    check_reset();
                end
                @(negedge clk);
                release_reset();
            end else begin
                step();
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
